// File: rtl/noc_local_sink_pkg.sv
// Shared constants, header layout and helpers for the NoC local-port traffic sink.
package noc_local_sink_pkg;

  localparam int unsigned DATA_WIDTH = 512;
  localparam int unsigned MESH_SIDE  = 4;
  localparam int unsigned COORD_W    = $clog2(MESH_SIDE);
  localparam int unsigned SEQ_W      = 16;
  localparam int unsigned TS_W       = 32;

  // Header field offsets for the default mesh, LSB first.
  localparam int unsigned DEST_X_OFF = 0;
  localparam int unsigned DEST_Y_OFF = DEST_X_OFF + COORD_W;
  localparam int unsigned SRC_X_OFF  = DEST_Y_OFF + COORD_W;
  localparam int unsigned SRC_Y_OFF  = SRC_X_OFF + COORD_W;
  localparam int unsigned SEQ_OFF    = SRC_Y_OFF + COORD_W;
  localparam int unsigned TS_OFF     = SEQ_OFF + SEQ_W;
  localparam int unsigned HDR_W      = TS_OFF + TS_W;

  typedef struct packed {
    logic [TS_W-1:0]    tstamp;
    logic [SEQ_W-1:0]   seq;
    logic [COORD_W-1:0] src_y;
    logic [COORD_W-1:0] src_x;
    logic [COORD_W-1:0] dest_y;
    logic [COORD_W-1:0] dest_x;
  } flit_hdr_t;

  localparam logic [0:0] StRun  = 1'b0;
  localparam logic [0:0] StHalt = 1'b1;

  function automatic logic [47:0] sat_add48(input logic [47:0] a, input logic [31:0] b);
    logic [48:0] s;
    s = {1'b0, a} + {17'b0, b};
    return s[48] ? '1 : s[47:0];
  endfunction

endpackage

// File: rtl/lfsr_ready_gen.sv
// Pseudo-random ready generator: 16-bit Galois LFSR, registered percent gate.
module lfsr_ready_gen #(
  parameter int unsigned PERCENT = 100,
  parameter logic [15:0] SEED    = 16'hACE1
) (
  input  logic clk,
  input  logic rst,
  output logic ready
);

  logic [15:0] lfsr_q, lfsr_d;
  logic        ready_q;

  // x^16+x^14+x^13+x^11+1, right-shifting Galois form
  always_comb begin
    lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr_q  <= SEED;
      ready_q <= 1'b0;
    end else begin
      lfsr_q  <= lfsr_d;
      ready_q <= ((32'(lfsr_q) % 32'd100) < PERCENT);
    end
  end

  assign ready = ready_q;

endmodule

// File: rtl/noc_local_sink.sv
// Local-port traffic sink: random backpressure, destination and per-source sequence
// checks, receive count and latency statistics.
module noc_local_sink #(
  parameter int unsigned DATA_WIDTH    = noc_local_sink_pkg::DATA_WIDTH,
  parameter int unsigned MESH_SIDE     = noc_local_sink_pkg::MESH_SIDE,
  parameter int unsigned X_POS         = 0,
  parameter int unsigned Y_POS         = 0,
  parameter int unsigned READY_PERCENT = 100,
  parameter logic [15:0] LFSR_SEED     = 16'hACE1,
  parameter bit          HALT_ON_ERROR = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  clear,
  output logic [31:0]           rx_count,
  output logic [47:0]           lat_sum,
  output logic [31:0]           lat_max,
  output logic                  err_dest,
  output logic                  err_seq,
  output logic                  halted
);
  import noc_local_sink_pkg::*;

  localparam int unsigned CW     = $clog2(MESH_SIDE);
  localparam int unsigned SeqOff = 4 * CW;
  localparam int unsigned TsOff  = SeqOff + SEQ_W;
  localparam int unsigned HdrW   = TsOff + TS_W;
  // Indexed by {src_y, src_x}; equals MESH_SIDE^2 entries for power-of-two meshes.
  localparam int unsigned NumSrc = 1 << (2 * CW);
  localparam logic [CW-1:0] MyX  = CW'(X_POS);
  localparam logic [CW-1:0] MyY  = CW'(Y_POS);

  logic [CW-1:0]    dest_x, dest_y, src_x, src_y;
  logic [SEQ_W-1:0] seq;
  logic [TS_W-1:0]  tstamp;
  logic [2*CW-1:0]  src_idx;
  logic             unused_payload;

  assign dest_x         = in_data[0 +: CW];
  assign dest_y         = in_data[CW +: CW];
  assign src_x          = in_data[2*CW +: CW];
  assign src_y          = in_data[3*CW +: CW];
  assign seq            = in_data[SeqOff +: SEQ_W];
  assign tstamp         = in_data[TsOff +: TS_W];
  assign src_idx        = {src_y, src_x};
  assign unused_payload = ^in_data[DATA_WIDTH-1:HdrW];

  logic             ready_bp;
  logic [0:0]       state_q;
  logic [31:0]      now_q, rx_q, lat_max_q;
  logic [47:0]      lat_sum_q;
  logic             err_dest_q, err_seq_q;
  logic [SEQ_W-1:0] exp_seq_q [NumSrc];

  lfsr_ready_gen #(
    .PERCENT(READY_PERCENT),
    .SEED   (LFSR_SEED)
  ) u_ready_gen (
    .clk  (clk),
    .rst  (rst),
    .ready(ready_bp)
  );

  logic        accept, dest_ok, seq_ok;
  logic [31:0] lat;

  assign in_ready = (state_q == StRun) && ready_bp;
  assign accept   = in_valid && in_ready;
  assign dest_ok  = ({dest_y, dest_x} == {MyY, MyX});
  assign seq_ok   = (seq == exp_seq_q[src_idx]);
  assign lat      = now_q - tstamp;

  // clear wins over a simultaneous accept: that flit is consumed but not checked
  always_ff @(posedge clk) begin
    if (rst) begin
      now_q      <= '0;
      state_q    <= StRun;
      rx_q       <= '0;
      lat_sum_q  <= '0;
      lat_max_q  <= '0;
      err_dest_q <= 1'b0;
      err_seq_q  <= 1'b0;
      for (int i = 0; i < NumSrc; i++) exp_seq_q[i] <= '0;
    end else begin
      now_q <= now_q + 32'd1;
      if (clear) begin
        state_q    <= StRun;
        rx_q       <= '0;
        lat_sum_q  <= '0;
        lat_max_q  <= '0;
        err_dest_q <= 1'b0;
        err_seq_q  <= 1'b0;
        for (int i = 0; i < NumSrc; i++) exp_seq_q[i] <= '0;
      end else if (accept) begin
        rx_q <= rx_q + 32'd1;
        if (!dest_ok) begin
          err_dest_q <= 1'b1;
        end else begin
          if (!seq_ok) err_seq_q <= 1'b1;
          exp_seq_q[src_idx] <= seq + 16'd1;
          lat_sum_q          <= sat_add48(lat_sum_q, lat);
          if (lat > lat_max_q) lat_max_q <= lat;
        end
        if (HALT_ON_ERROR && (!dest_ok || !seq_ok)) state_q <= StHalt;
      end
    end
  end

  assign rx_count = rx_q;
  assign lat_sum  = lat_sum_q;
  assign lat_max  = lat_max_q;
  assign err_dest = err_dest_q;
  assign err_seq  = err_seq_q;
  assign halted   = (state_q == StHalt);

endmodule

// File: tb/tb_noc_local_sink.sv
// Randomised self-checking bench: three sink instances checked against a behavioural model.
module tb_noc_local_sink;

  localparam int DW   = 512;
  localparam int NDUT = 3;
  localparam longint unsigned SAT48 = 64'hFFFF_FFFF_FFFF;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [DW-1:0] in_data  [NDUT];
  logic          in_valid [NDUT];
  logic          clear    [NDUT];
  logic          in_ready [NDUT];
  logic [31:0]   rx_count [NDUT];
  logic [47:0]   lat_sum  [NDUT];
  logic [31:0]   lat_max  [NDUT];
  logic          err_dest [NDUT];
  logic          err_seq  [NDUT];
  logic          halted   [NDUT];

  int vectors     = 0;
  int miscompares = 0;

  // Behavioural model state, one slot per instance
  logic [31:0]     now_m;
  int unsigned     m_rx   [NDUT];
  longint unsigned m_sum  [NDUT];
  longint unsigned m_max  [NDUT];
  bit              m_ed   [NDUT];
  bit              m_es   [NDUT];
  bit              m_halt [NDUT];
  int unsigned     m_exp  [NDUT][16];

  string nm [7] = '{"rx_count", "lat_sum", "lat_max", "err_dest", "err_seq", "halted",
                    "in_ready"};

  always #5 clk = ~clk;
  always @(posedge clk) now_m <= rst ? 32'd0 : now_m + 32'd1;

  // 0: node (1,2) halts on error; 1: node (1,2) keeps running; 2: node (0,0) at 50% ready
  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    noc_local_sink #(
      .DATA_WIDTH   (DW),
      .MESH_SIDE    (4),
      .X_POS        ((g == 2) ? 0 : 1),
      .Y_POS        ((g == 2) ? 0 : 2),
      .READY_PERCENT((g == 2) ? 50 : 100),
      .LFSR_SEED    (16'hACE1),
      .HALT_ON_ERROR(g != 1)
    ) u_dut (
      .clk     (clk),
      .rst     (rst),
      .in_data (in_data[g]),
      .in_valid(in_valid[g]),
      .in_ready(in_ready[g]),
      .clear   (clear[g]),
      .rx_count(rx_count[g]),
      .lat_sum (lat_sum[g]),
      .lat_max (lat_max[g]),
      .err_dest(err_dest[g]),
      .err_seq (err_seq[g]),
      .halted  (halted[g])
    );
  end

  function automatic int px(input int d); return (d == 2) ? 0 : 1; endfunction
  function automatic int py(input int d); return (d == 2) ? 0 : 2; endfunction

  function automatic logic [DW-1:0] mk_flit(input int dx, input int dy, input int sx,
                                            input int sy, input int unsigned sq,
                                            input logic [31:0] ts);
    logic [DW-1:0] f;
    for (int i = 0; i < DW / 32; i++) f[i*32 +: 32] = $urandom;
    f[1:0]   = 2'(dx);
    f[3:2]   = 2'(dy);
    f[5:4]   = 2'(sx);
    f[7:6]   = 2'(sy);
    f[23:8]  = 16'(sq);
    f[55:24] = ts;
    return f;
  endfunction

  task automatic m_clear(input int d);
    m_rx[d] = 0; m_sum[d] = 0; m_max[d] = 0;
    m_ed[d] = 0; m_es[d] = 0; m_halt[d] = 0;
    for (int s = 0; s < 16; s++) m_exp[d][s] = 0;
  endtask

  // Apply one accepted flit to the model, using the counter value at the accepting edge
  task automatic m_accept(input int d, input int dx, input int dy, input int sx, input int sy,
                          input int unsigned sq, input logic [31:0] ts);
    bit          err;
    logic [31:0] lat;
    int          s;
    err     = 0;
    m_rx[d] = m_rx[d] + 1;
    if (dx != px(d) || dy != py(d)) begin
      m_ed[d] = 1; err = 1;
    end else begin
      s = sy * 4 + sx;
      if (sq != m_exp[d][s]) begin m_es[d] = 1; err = 1; end
      m_exp[d][s] = (sq + 1) % 65536;
      lat      = now_m - ts;
      m_sum[d] = m_sum[d] + longint'(lat);
      if (m_sum[d] > SAT48) m_sum[d] = SAT48;
      if (longint'(lat) > m_max[d]) m_max[d] = longint'(lat);
    end
    if (err && d != 1) m_halt[d] = 1;
  endtask

  task automatic present(input int d, input int dx, input int dy, input int sx, input int sy,
                         input int unsigned sq, input logic [31:0] ts);
    in_data[d]  = mk_flit(dx, dy, sx, sy, sq, ts);
    in_valid[d] = 1'b1;
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  // Gather observed and expected status; in_rst forces the reset value of in_ready
  task automatic snap(input int d, input bit in_rst, output logic [63:0] a [7],
                      output logic [63:0] e [7]);
    a[0] = 64'(rx_count[d]); a[1] = 64'(lat_sum[d]); a[2] = 64'(lat_max[d]);
    a[3] = 64'(err_dest[d]); a[4] = 64'(err_seq[d]); a[5] = 64'(halted[d]);
    a[6] = 64'(in_ready[d]);
    e[0] = 64'(m_rx[d]); e[1] = m_sum[d]; e[2] = m_max[d];
    e[3] = 64'(m_ed[d]); e[4] = 64'(m_es[d]); e[5] = 64'(m_halt[d]);
    e[6] = (in_rst || d == 2) ? 64'd0 : 64'(!m_halt[d]);
  endtask

  task automatic test_reset();
    logic [63:0] a [7];
    logic [63:0] e [7];
    rst = 1'b1;
    for (int d = 0; d < NDUT; d++) begin
      in_valid[d] = 1'b0; clear[d] = 1'b0; in_data[d] = '0; m_clear(d);
    end
    cycle();
    cycle();
    for (int d = 0; d < NDUT; d++) begin
      snap(d, 1'b1, a, e);
      for (int i = 0; i < 7; i++) begin
        vectors++;
        if (a[i] !== e[i]) begin
          miscompares++;
          $display("FAIL reset.dut%0d.%s: got %0d, expected %0d", d, nm[i], a[i], e[i]);
        end
      end
    end
    rst = 1'b0;
    cycle();
    for (int d = 0; d < 2; d++) begin
      vectors++;
      if (in_ready[d] !== 1'b1) begin
        miscompares++;
        $display("FAIL reset.first_ready dut%0d: got %b, expected 1", d, in_ready[d]);
      end
    end
  endtask

  task automatic test_in_order();
    logic [63:0] a [7];
    logic [63:0] e [7];
    int sx, sy;
    int unsigned sq;
    logic [31:0] ts;
    for (int k = 0; k < 5; k++) begin
      vectors++;
      if (in_ready[0] !== 1'b1) begin
        miscompares++;
        $display("FAIL in_order.ready[%0d]: got %b, expected 1", k, in_ready[0]);
      end
      present(0, 1, 2, 0, 0, k, now_m - 32'd7);
      m_accept(0, 1, 2, 0, 0, k, now_m - 32'd7);
      cycle();
    end
    in_valid[0] = 1'b0;
    snap(0, 1'b0, a, e);
    for (int i = 0; i < 7; i++) begin
      vectors++;
      if (a[i] !== e[i]) begin
        miscompares++;
        $display("FAIL in_order.%s: got %0d, expected %0d", nm[i], a[i], e[i]);
      end
    end
    // Random sources, in-order sequences, arbitrary timestamps (latency wraps mod 2^32)
    for (int k = 0; k < 24; k++) begin
      if ($urandom_range(0, 3) == 0) begin
        in_valid[0] = 1'b0;
      end else begin
        sx = int'($urandom_range(0, 3));
        sy = int'($urandom_range(0, 3));
        sq = m_exp[0][sy * 4 + sx];
        ts = $urandom;
        present(0, 1, 2, sx, sy, sq, ts);
        m_accept(0, 1, 2, sx, sy, sq, ts);
      end
      cycle();
    end
    in_valid[0] = 1'b0;
    snap(0, 1'b0, a, e);
    for (int i = 0; i < 7; i++) begin
      vectors++;
      if (a[i] !== e[i]) begin
        miscompares++;
        $display("FAIL in_order_rand.%s: got %0d, expected %0d", nm[i], a[i], e[i]);
      end
    end
  endtask

  task automatic test_dest_err();
    logic [63:0] a [7];
    logic [63:0] e [7];
    present(0, 3, 3, 0, 0, m_exp[0][0], now_m - 32'd5);
    m_accept(0, 3, 3, 0, 0, m_exp[0][0], now_m - 32'd5);
    cycle();
    // Keep offering while halted: nothing may be accepted
    present(0, 1, 2, 0, 0, m_exp[0][0], now_m);
    snap(0, 1'b0, a, e);
    for (int i = 0; i < 7; i++) begin
      vectors++;
      if (a[i] !== e[i]) begin
        miscompares++;
        $display("FAIL dest_err.%s: got %0d, expected %0d", nm[i], a[i], e[i]);
      end
    end
    cycle();
    cycle();
    in_valid[0] = 1'b0;
    snap(0, 1'b0, a, e);
    for (int i = 0; i < 7; i++) begin
      vectors++;
      if (a[i] !== e[i]) begin
        miscompares++;
        $display("FAIL halt_hold.%s: got %0d, expected %0d", nm[i], a[i], e[i]);
      end
    end
    clear[0] = 1'b1;
    m_clear(0);
    cycle();
    clear[0] = 1'b0;
    snap(0, 1'b0, a, e);
    for (int i = 0; i < 7; i++) begin
      vectors++;
      if (a[i] !== e[i]) begin
        miscompares++;
        $display("FAIL clear.%s: got %0d, expected %0d", nm[i], a[i], e[i]);
      end
    end
    // Clear beats a simultaneous accept: a bad-sequence flit is swallowed unchecked
    clear[0] = 1'b1;
    present(0, 1, 2, 0, 0, 9, now_m);
    cycle();
    clear[0] = 1'b0;
    present(0, 1, 2, 0, 0, 0, now_m - 32'd3);
    m_accept(0, 1, 2, 0, 0, 0, now_m - 32'd3);
    cycle();
    in_valid[0] = 1'b0;
    snap(0, 1'b0, a, e);
    for (int i = 0; i < 7; i++) begin
      vectors++;
      if (a[i] !== e[i]) begin
        miscompares++;
        $display("FAIL clear_prio.%s: got %0d, expected %0d", nm[i], a[i], e[i]);
      end
    end
  endtask

  task automatic test_seq_err();
    logic [63:0] a [7];
    logic [63:0] e [7];
    int unsigned seqs [4] = '{0, 1, 3, 4};
    logic [31:0] ts;
    for (int k = 0; k < 4; k++) begin
      ts = now_m - $urandom_range(0, 100);
      present(1, 1, 2, 2, 1, seqs[k], ts);
      m_accept(1, 1, 2, 2, 1, seqs[k], ts);
      cycle();
      snap(1, 1'b0, a, e);
      for (int i = 0; i < 7; i++) begin
        vectors++;
        if (a[i] !== e[i]) begin
          miscompares++;
          $display("FAIL seq_err[%0d].%s: got %0d, expected %0d", k, nm[i], a[i], e[i]);
        end
      end
    end
    in_valid[1] = 1'b0;
  endtask

  task automatic test_seq_wrap();
    logic [63:0] a [7];
    logic [63:0] e [7];
    int unsigned seqs [3] = '{65534, 65535, 0};
    clear[1] = 1'b1;
    m_clear(1);
    cycle();
    clear[1] = 1'b0;
    for (int k = 0; k < 3; k++) begin
      present(1, 1, 2, 3, 0, seqs[k], now_m - 32'd2);
      m_accept(1, 1, 2, 3, 0, seqs[k], now_m - 32'd2);
      cycle();
      snap(1, 1'b0, a, e);
      for (int i = 0; i < 7; i++) begin
        vectors++;
        if (a[i] !== e[i]) begin
          miscompares++;
          $display("FAIL seq_wrap[%0d].%s: got %0d, expected %0d", k, nm[i], a[i], e[i]);
        end
      end
    end
    in_valid[1] = 1'b0;
  endtask

  task automatic test_backpressure();
    logic [63:0] a [7];
    logic [63:0] e [7];
    int acc_n;
    int sx, sy;
    int unsigned sq;
    logic [31:0] ts;
    bit need;
    acc_n = 0; need = 1; sx = 0; sy = 0; sq = 0; ts = '0;
    for (int c = 0; c < 2000; c++) begin
      if (need) begin
        sx = int'($urandom_range(0, 3));
        sy = int'($urandom_range(0, 3));
        sq = m_exp[2][sy * 4 + sx];
        ts = now_m - $urandom_range(0, 50);
        present(2, 0, 0, sx, sy, sq, ts);
      end
      need = (in_ready[2] === 1'b1);
      if (need) begin
        m_accept(2, 0, 0, sx, sy, sq, ts);
        acc_n++;
      end
      cycle();
    end
    in_valid[2] = 1'b0;
    cycle();
    snap(2, 1'b0, a, e);
    for (int i = 0; i < 6; i++) begin
      vectors++;
      if (a[i] !== e[i]) begin
        miscompares++;
        $display("FAIL backpressure.%s: got %0d, expected %0d", nm[i], a[i], e[i]);
      end
    end
    vectors++;
    if (acc_n < 800 || acc_n > 1200) begin
      miscompares++;
      $display("FAIL backpressure.ratio: got %0d accepts of 2000, expected 800..1200", acc_n);
    end
  endtask

  task automatic test_mid_reset();
    logic [63:0] a [7];
    logic [63:0] e [7];
    for (int k = 0; k < 3; k++) begin
      present(0, 1, 2, 1, 1, m_exp[0][5], now_m - 32'd2);
      m_accept(0, 1, 2, 1, 1, m_exp[0][5], now_m - 32'd2);
      cycle();
    end
    rst = 1'b1;
    present(0, 1, 2, 1, 1, m_exp[0][5], now_m - 32'd2);
    cycle();
    rst = 1'b0;
    for (int d = 0; d < NDUT; d++) m_clear(d);
    present(0, 1, 2, 1, 1, 0, now_m - 32'd4);
    for (int d = 0; d < NDUT; d++) begin
      snap(d, 1'b1, a, e);
      for (int i = 0; i < 7; i++) begin
        vectors++;
        if (a[i] !== e[i]) begin
          miscompares++;
          $display("FAIL mid_reset.dut%0d.%s: got %0d, expected %0d", d, nm[i], a[i], e[i]);
        end
      end
    end
    cycle();
    snap(0, 1'b0, a, e);
    for (int i = 0; i < 7; i++) begin
      vectors++;
      if (a[i] !== e[i]) begin
        miscompares++;
        $display("FAIL post_reset_idle.%s: got %0d, expected %0d", nm[i], a[i], e[i]);
      end
    end
    m_accept(0, 1, 2, 1, 1, 0, now_m - 32'd4 - 32'd1);
    cycle();
    in_valid[0] = 1'b0;
    snap(0, 1'b0, a, e);
    for (int i = 0; i < 7; i++) begin
      vectors++;
      if (a[i] !== e[i]) begin
        miscompares++;
        $display("FAIL post_reset_seq0.%s: got %0d, expected %0d", nm[i], a[i], e[i]);
      end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_in_order();
    test_dest_err();
    test_seq_err();
    test_seq_wrap();
    test_backpressure();
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
